multi_chan_fifo: RTL and testbench
==================================

Name: multi_chan_fifo

Overview:
- Parametrised successor to the single-lane fifo DUT driven by the fifo_in/fifo_out agents.
- Holds NUM_CH independent synchronous FIFOs, each with its own valid/ready input and output channel.
- Channel k of the packed buses maps to agent pair fifo_in<k>_if / fifo_out<k>_if in the testbench harness.
- Adds per-channel fill-level reporting and first-word-fall-through output; the previous generation had neither.

Parameters:
- NUM_CH, 2, number of independent channels (>=1).
- DATA_W, 8, payload width per channel.
- DEPTH, 4, entries per channel FIFO; power of two, >=2.
- AF_THRESH, 3, almost-full threshold; used only with the optional feature; 1..DEPTH.
- LVL_W = $clog2(DEPTH)+1, derived localparam.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  NUM_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
- data_in_vld  in  NUM_CH  per-channel input valid.
- data_in_rdy  out  NUM_CH  per-channel input ready.
- data_out  out  NUM_CH*DATA_W  per-channel head-of-FIFO payload.
- data_out_vld  out  NUM_CH  per-channel output valid.
- data_out_rdy  in  NUM_CH  per-channel output ready (from consumer).
- fill_level  out  NUM_CH*LVL_W  per-channel occupancy, 0..DEPTH.
- almost_full  out  NUM_CH  optional; present only with MULTI_CHAN_FIFO_AF_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd/wr pointers, fill_level and a per-block run flag all go to 0.
  - data_in_rdy=0, data_out_vld=0, data_out=0, almost_full=0.
  - Storage array is not reset.
- Run flag: set on the first clk edge after rst deasserts. data_in_rdy is held at 0 until the run flag is set, so there is exactly one cycle of rdy=0 after release.
- Channels are fully independent. No arbitration, and no shared state other than clk/rst/run flag.
- Push: on a clk edge where data_in_vld[k] && data_in_rdy[k]. Writes to mem[k][wr_ptr], then wr_ptr++.
- Pop: on a clk edge where data_out_vld[k] && data_out_rdy[k]. Then rd_ptr++.
- Pointers are LVL_W bits and wrap modulo 2*DEPTH. Full/empty is decided by MSB compare:
  - empty: ptrs equal.
  - full: low bits equal and MSBs differ.
- data_in_rdy[k] = run && !full[k]. Combinational from registered state only; no dependence on data_out_rdy (no pop-through when full).
- data_out_vld[k] = !empty[k].
- data_out[k] = mem[k][rd_ptr] (FWFT) when valid, 0 when not valid.
- Latency:
  - Word pushed at edge N appears on data_out with vld=1 after edge N: one cycle, empty to valid.
  - Pop at edge N makes the next entry (if any) visible after edge N.
- Simultaneous push and pop on the same channel:
  - Both occur; fill_level is unchanged.
  - Legal at any level 1..DEPTH-1.
  - At level 0 only the push occurs (vld=0). At level DEPTH only the pop occurs (rdy=0).
- fill_level[k] = wr_ptr - rd_ptr (mod 2*DEPTH), registered, updated the same edge as the pointers.
- Ordering: strict FIFO per channel; no data loss, no duplication.
- Inputs asserted while rdy=0 are ignored. Producers hold data/vld until accepted; the block does not check this.
- Reset mid-operation: all contents are discarded immediately (async). Post-release behaviour is identical to power-up.

Optional Feature:
- Macro: MULTI_CHAN_FIFO_AF_EN.
- Defined:
  - almost_full port exists.
  - almost_full[k] is registered and equals (next fill_level[k] >= AF_THRESH), so it is asserted the same cycle fill_level reaches the threshold.
  - Reset value is 0.
- Undefined: port and logic are absent; AF_THRESH is unused.

Test Plan (NUM_CH=2, DATA_W=8, DEPTH=4, AF_THRESH=3):
1. Release rst at t=75ns -> data_in_rdy=2'b00 for one clk, then 2'b11; data_out_vld=2'b00; fill_level all 0.
2. Ch0 pushes 0x11,0x22,0x33,0x44 with data_out_rdy=0 -> fill_level[0]=4, data_in_rdy[0]=0, data_out[0]=0x11. A fifth push of 0x55 is ignored. Ch1 is untouched (level 0, rdy=1).
3. Ch0 drains with data_out_rdy[0]=1 every cycle -> output 0x11,0x22,0x33,0x44 on consecutive cycles, then vld=0 and data_out[0]=0.
4. Ch1 at level 2 (0xA0,0xA1), push 0xA2 and pop in the same cycle -> level stays 2, head becomes 0xA1. Keep both every cycle for 10 cycles -> pointers wrap and order is preserved.
5. Ch0 at level 4: assert data_in_vld and data_out_rdy together -> only the pop occurs (level 3). Push on the next cycle -> level 4.
6. Ch0 at level 3, pulse rst low mid-cycle -> outputs are 0 immediately, without waiting for a clock edge. After release, level is 0 and stale data never appears. With MULTI_CHAN_FIFO_AF_EN, almost_full[0] rises when level reaches 3 and falls when it drops to 2.

Source files
------------

// File: rtl/multi_chan_fifo.sv
// multi_chan_fifo: NUM_CH independent first-word-fall-through FIFOs with per-channel fill level.
// Define MULTI_CHAN_FIFO_AF_EN to add the registered per-channel almost_full output.
module multi_chan_fifo #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*DATA_W-1:0]  data_in,
  input  logic [NUM_CH-1:0]         data_in_vld,
  output logic [NUM_CH-1:0]         data_in_rdy,
  output logic [NUM_CH*DATA_W-1:0]  data_out,
  output logic [NUM_CH-1:0]         data_out_vld,
  input  logic [NUM_CH-1:0]         data_out_rdy,
  output logic [NUM_CH*LVL_W-1:0]   fill_level
`ifdef MULTI_CHAN_FIFO_AF_EN
  ,
  output logic [NUM_CH-1:0]         almost_full
`endif
);

  localparam int AW = LVL_W - 1;

  if (NUM_CH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_param
    $error("multi_chan_fifo: illegal parameter combination");
  end

  // Held low for exactly one edge after reset release so producers see rdy=0 first.
  logic run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]  wr_q, wr_d, rd_q, rd_d, lvl_q, lvl_d;
    logic              full, empty, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign data_in_rdy[k]  = run_q && !full;
    assign data_out_vld[k] = !empty;
    assign data_out[k*DATA_W +: DATA_W] = empty ? '0 : mem_q[rd_q[AW-1:0]];

    assign push  = data_in_vld[k] && data_in_rdy[k];
    assign pop   = data_out_vld[k] && data_out_rdy[k];
    assign wr_d  = wr_q + LVL_W'(push);
    assign rd_d  = rd_q + LVL_W'(pop);
    assign lvl_d = wr_d - rd_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        lvl_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        lvl_q <= lvl_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= data_in[k*DATA_W +: DATA_W];
    end

    assign fill_level[k*LVL_W +: LVL_W] = lvl_q;

`ifdef MULTI_CHAN_FIFO_AF_EN
    logic af_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) af_q <= 1'b0;
      else      af_q <= (lvl_d >= LVL_W'(AF_THRESH));
    end

    assign almost_full[k] = af_q;
`endif
  end

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Directed self-checking bench for multi_chan_fifo at NUM_CH=2, DATA_W=8, DEPTH=4, AF_THRESH=3.
// Compile with MULTI_CHAN_FIFO_AF_EN defined to also check almost_full.
module tb_multi_chan_fifo;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF_TH  = 3;
  localparam int LVL_W  = 3;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        data_in_vld;
  logic [NUM_CH-1:0]        data_in_rdy;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        data_out_vld;
  logic [NUM_CH-1:0]        data_out_rdy;
  logic [NUM_CH*LVL_W-1:0]  fill_level;
`ifdef MULTI_CHAN_FIFO_AF_EN
  logic [NUM_CH-1:0]        almost_full;
`endif

  int errors = 0;
  int checks = 0;

  multi_chan_fifo #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_vld(data_in_vld),
    .data_in_rdy(data_in_rdy),
    .data_out(data_out),
    .data_out_vld(data_out_vld),
    .data_out_rdy(data_out_rdy),
    .fill_level(fill_level)
`ifdef MULTI_CHAN_FIFO_AF_EN
    ,
    .almost_full(almost_full)
`endif
  );

  // Rising edges at 10, 20, 30 ... so the 75 ns release falls between edges.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [7:0] dout(input int k);
    return data_out[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [2:0] lvl(input int k);
    return fill_level[k*LVL_W +: LVL_W];
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    data_in = '0;
    data_in_vld = '0;
    data_out_rdy = '0;
    #75 rst = 1'b1;
    #2;
    checks++;
    if (data_in_rdy !== 2'b00) begin
      errors++; $display("FAIL reset_rdy_first: got %b expected 00", data_in_rdy);
    end
    checks++;
    if (data_out_vld !== 2'b00) begin
      errors++; $display("FAIL reset_vld: got %b expected 00", data_out_vld);
    end
    checks++;
    if (fill_level !== 6'd0) begin
      errors++; $display("FAIL reset_level: got %h expected 0", fill_level);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_dout: got %h expected 0000", data_out);
    end
`ifdef MULTI_CHAN_FIFO_AF_EN
    checks++;
    if (almost_full !== 2'b00) begin
      errors++; $display("FAIL reset_af: got %b expected 00", almost_full);
    end
`endif
    @(negedge clk);
    checks++;
    if (data_in_rdy !== 2'b11) begin
      errors++; $display("FAIL reset_rdy_run: got %b expected 11", data_in_rdy);
    end
    checks++;
    if (data_out_vld !== 2'b00 || fill_level !== 6'd0) begin
      errors++; $display("FAIL reset_idle: got vld=%b lvl=%h expected vld=00 lvl=0", data_out_vld, fill_level);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      data_in[7:0] = 8'(8'h11 * (i + 1));
      data_in_vld[0] = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (data_out_vld[0] !== 1'b1 || dout(0) !== 8'h11) begin
          errors++; $display("FAIL fill_fwft: got vld=%b d=%h expected vld=1 d=11", data_out_vld[0], dout(0));
        end
      end
    end
    checks++;
    if (lvl(0) !== 3'd4 || data_in_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL fill_full: got lvl=%0d rdy=%b expected lvl=4 rdy=0", lvl(0), data_in_rdy[0]);
    end
    checks++;
    if (dout(0) !== 8'h11) begin
      errors++; $display("FAIL fill_head: got %h expected 11", dout(0));
    end
    checks++;
    if (lvl(1) !== 3'd0 || data_in_rdy[1] !== 1'b1 || data_out_vld[1] !== 1'b0) begin
      errors++; $display("FAIL fill_ch1_idle: got lvl=%0d rdy=%b vld=%b expected 0 1 0", lvl(1), data_in_rdy[1], data_out_vld[1]);
    end
    data_in[7:0] = 8'h55;
    @(negedge clk);
    checks++;
    if (lvl(0) !== 3'd4 || dout(0) !== 8'h11) begin
      errors++; $display("FAIL fill_overflow: got lvl=%0d d=%h expected lvl=4 d=11", lvl(0), dout(0));
    end
    data_in_vld[0] = 1'b0;
  endtask

  task automatic test_drain();
    data_out_rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out_vld[0] !== 1'b1 || dout(0) !== 8'(8'h11 * (i + 1))) begin
        errors++; $display("FAIL drain_word%0d: got vld=%b d=%h expected vld=1 d=%h", i, data_out_vld[0], dout(0), 8'(8'h11 * (i + 1)));
      end
      @(negedge clk);
    end
    checks++;
    if (data_out_vld[0] !== 1'b0 || dout(0) !== 8'h00 || lvl(0) !== 3'd0) begin
      errors++; $display("FAIL drain_empty: got vld=%b d=%h lvl=%0d expected 0 00 0", data_out_vld[0], dout(0), lvl(0));
    end
    data_out_rdy[0] = 1'b0;
  endtask

  task automatic test_simul();
    data_in[15:8] = 8'hA0;
    data_in_vld[1] = 1'b1;
    @(negedge clk);
    data_in[15:8] = 8'hA1;
    @(negedge clk);
    checks++;
    if (lvl(1) !== 3'd2 || dout(1) !== 8'hA0) begin
      errors++; $display("FAIL simul_pre: got lvl=%0d d=%h expected lvl=2 d=a0", lvl(1), dout(1));
    end
    data_out_rdy[1] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      data_in[15:8] = 8'(8'hA2 + i);
      @(negedge clk);
      checks++;
      if (lvl(1) !== 3'd2 || dout(1) !== 8'(8'hA1 + i)) begin
        errors++; $display("FAIL simul_cycle%0d: got lvl=%0d d=%h expected lvl=2 d=%h", i, lvl(1), dout(1), 8'(8'hA1 + i));
      end
    end
    data_in_vld[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (dout(1) !== 8'hAC || lvl(1) !== 3'd1) begin
      errors++; $display("FAIL simul_tail: got lvl=%0d d=%h expected lvl=1 d=ac", lvl(1), dout(1));
    end
    @(negedge clk);
    checks++;
    if (lvl(1) !== 3'd0 || data_out_vld[1] !== 1'b0) begin
      errors++; $display("FAIL simul_drained: got lvl=%0d vld=%b expected 0 0", lvl(1), data_out_vld[1]);
    end
    data_out_rdy[1] = 1'b0;
  endtask

  task automatic test_full_simul();
    data_in_vld[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in[7:0] = 8'(8'hB0 + i);
      @(negedge clk);
`ifdef MULTI_CHAN_FIFO_AF_EN
      if (i == 1) begin
        checks++;
        if (almost_full[0] !== 1'b0) begin
          errors++; $display("FAIL af_below: got %b expected 0", almost_full[0]);
        end
      end
      if (i == 2) begin
        checks++;
        if (almost_full[0] !== 1'b1) begin
          errors++; $display("FAIL af_rise: got %b expected 1", almost_full[0]);
        end
      end
`endif
    end
    checks++;
    if (lvl(0) !== 3'd4) begin
      errors++; $display("FAIL full_level: got %0d expected 4", lvl(0));
    end
    data_in[7:0] = 8'hB4;
    data_out_rdy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (lvl(0) !== 3'd3 || dout(0) !== 8'hB1) begin
      errors++; $display("FAIL full_pop_only: got lvl=%0d d=%h expected lvl=3 d=b1", lvl(0), dout(0));
    end
    data_out_rdy[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (lvl(0) !== 3'd4 || dout(0) !== 8'hB1) begin
      errors++; $display("FAIL full_refill: got lvl=%0d d=%h expected lvl=4 d=b1", lvl(0), dout(0));
    end
    data_in_vld[0] = 1'b0;
    data_out_rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (lvl(0) !== 3'd2 || dout(0) !== 8'hB3) begin
      errors++; $display("FAIL full_pop2: got lvl=%0d d=%h expected lvl=2 d=b3", lvl(0), dout(0));
    end
`ifdef MULTI_CHAN_FIFO_AF_EN
    checks++;
    if (almost_full[0] !== 1'b0) begin
      errors++; $display("FAIL af_fall: got %b expected 0", almost_full[0]);
    end
`endif
    data_out_rdy[0] = 1'b0;
    data_in[7:0] = 8'hB5;
    data_in_vld[0] = 1'b1;
    @(negedge clk);
    data_in_vld[0] = 1'b0;
    checks++;
    if (lvl(0) !== 3'd3) begin
      errors++; $display("FAIL full_lvl3: got %0d expected 3", lvl(0));
    end
  endtask

  task automatic test_async_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (data_out_vld !== 2'b00 || data_out !== 16'h0000) begin
      errors++; $display("FAIL areset_out: got vld=%b d=%h expected 00 0000", data_out_vld, data_out);
    end
    checks++;
    if (fill_level !== 6'd0 || data_in_rdy !== 2'b00) begin
      errors++; $display("FAIL areset_state: got lvl=%h rdy=%b expected 0 00", fill_level, data_in_rdy);
    end
`ifdef MULTI_CHAN_FIFO_AF_EN
    checks++;
    if (almost_full !== 2'b00) begin
      errors++; $display("FAIL areset_af: got %b expected 00", almost_full);
    end
`endif
    #1 rst = 1'b1;
    #1;
    checks++;
    if (data_in_rdy !== 2'b00) begin
      errors++; $display("FAIL areset_rdy_first: got %b expected 00", data_in_rdy);
    end
    @(negedge clk);
    checks++;
    if (data_in_rdy !== 2'b11 || data_out_vld !== 2'b00 || data_out !== 16'h0000) begin
      errors++; $display("FAIL areset_run: got rdy=%b vld=%b d=%h expected 11 00 0000", data_in_rdy, data_out_vld, data_out);
    end
    data_in[7:0] = 8'h5A;
    data_in_vld[0] = 1'b1;
    @(negedge clk);
    data_in_vld[0] = 1'b0;
    checks++;
    if (lvl(0) !== 3'd1 || dout(0) !== 8'h5A) begin
      errors++; $display("FAIL areset_fresh: got lvl=%0d d=%h expected lvl=1 d=5a", lvl(0), dout(0));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_full_simul();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
